// File: rtl/mem_row_arbiter_if.sv
// rtl/mem_row_arbiter_if.sv - requester handshakes and shared row-bank bus for mem_row_arbiter
interface mem_row_arbiter_if #(
    parameter int ROWS   = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic                   req_a;
    logic                   we_a;
    logic [ADDR_W-1:0]      addr_a;
    logic [DATA_W-1:0]      wdata_a;
    logic                   done_a;
    logic                   err_a;
    logic [DATA_W-1:0]      rdata_a;

    logic                   req_b;
    logic                   we_b;
    logic [ADDR_W-1:0]      addr_b;
    logic [DATA_W-1:0]      wdata_b;
    logic                   done_b;
    logic                   err_b;
    logic [DATA_W-1:0]      rdata_b;

    logic [ROWS-1:0]        row_S;
    logic                   row_op;
    logic [DATA_W-1:0]      row_data_in;
    logic [ROWS*DATA_W-1:0] row_data_out;

    // master: requesters plus the row bank; slave: the arbiter
    modport master (
        output req_a, we_a, addr_a, wdata_a,
        input  done_a, err_a, rdata_a,
        output req_b, we_b, addr_b, wdata_b,
        input  done_b, err_b, rdata_b,
        input  row_S, row_op, row_data_in,
        output row_data_out
    );

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        output done_a, err_a, rdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        output done_b, err_b, rdata_b,
        output row_S, row_op, row_data_in,
        input  row_data_out
    );
endinterface

// File: rtl/mem_row_arbiter.sv
// rtl/mem_row_arbiter.sv - round-robin two-requester controller sequencing a level-sensitive row bank
module mem_row_arbiter #(
    parameter int ROWS   = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    mem_row_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_b_q;
    logic              grant_b_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_cap_q;

    logic              take;
    logic              take_b;
    logic [ROWS-1:0]   sel;
    logic              in_range;
    logic [DATA_W-1:0] rd_sel;

    logic [ROWS-1:0]   s_d;
    logic              op_d;
    logic [DATA_W-1:0] din_d;
    logic              done_d;

    // An address with no matching row leaves sel empty, which doubles as the range check.
    always_comb begin
        sel    = '0;
        rd_sel = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                sel[i] = 1'b1;
                rd_sel = bus.row_data_out[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_range = |sel;

    always_comb begin
        take = bus.req_a | bus.req_b;
        if (bus.req_a && bus.req_b) begin
            take_b = ~last_b_q;
        end else begin
            take_b = bus.req_b;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  state_d = HOLD;
            HOLD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus values for the phase named by state_q; they reach the pins one edge later.
    always_comb begin
        s_d    = '0;
        op_d   = 1'b0;
        din_d  = '0;
        done_d = 1'b0;
        case (state_q)
            SETUP, HOLD: begin
                op_d  = we_q;
                din_d = we_q ? wdata_q : '0;
            end
            STROBE: begin
                op_d  = we_q;
                din_d = we_q ? wdata_q : '0;
                s_d   = sel;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            last_b_q        <= 1'b1;
            grant_b_q       <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rd_cap_q        <= '0;
            bus.row_S       <= '0;
            bus.row_op      <= 1'b0;
            bus.row_data_in <= '0;
            bus.done_a      <= 1'b0;
            bus.done_b      <= 1'b0;
            bus.err_a       <= 1'b0;
            bus.err_b       <= 1'b0;
            bus.rdata_a     <= '0;
            bus.rdata_b     <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && take) begin
                grant_b_q <= take_b;
                last_b_q  <= take_b;
                we_q      <= take_b ? bus.we_b    : bus.we_a;
                addr_q    <= take_b ? bus.addr_b  : bus.addr_a;
                wdata_q   <= take_b ? bus.wdata_b : bus.wdata_a;
            end

            // The pins show the strobe phase while state_q is HOLD, so sample the row now.
            if (state_q == HOLD) begin
                rd_cap_q <= rd_sel;
            end

            bus.row_S       <= s_d;
            bus.row_op      <= op_d;
            bus.row_data_in <= din_d;
            bus.done_a      <= done_d & ~grant_b_q;
            bus.done_b      <= done_d &  grant_b_q;
            bus.err_a       <= done_d & ~grant_b_q & ~in_range;
            bus.err_b       <= done_d &  grant_b_q & ~in_range;

            if (done_d && !we_q) begin
                if (grant_b_q) begin
                    bus.rdata_b <= rd_cap_q;
                end else begin
                    bus.rdata_a <= rd_cap_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_row_arbiter.sv
// tb/tb_mem_row_arbiter.sv - self-checking bench for mem_row_arbiter with a transaction-level model
module tb_mem_row_arbiter;
    localparam int ROWS   = 3;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_row_arbiter_if #(.ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_row_arbiter #(.ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Row bank: level-sensitive storage written while its S and op are high.
    logic [DATA_W-1:0] bank [ROWS] = '{default: '0};
    always @(negedge clk) begin
        for (int i = 0; i < ROWS; i++) begin
            if (bus.row_S[i] && bus.row_op) bank[i] = bus.row_data_in;
        end
    end
    always_comb begin
        for (int i = 0; i < ROWS; i++) bus.row_data_out[i*DATA_W +: DATA_W] = bank[i];
    end

    // Reference model: one transaction at a time, timed by edges since acceptance.
    logic [DATA_W-1:0] m_mem [ROWS] = '{default: '0};
    logic [DATA_W-1:0] m_rd_a = '0;
    logic [DATA_W-1:0] m_rd_b = '0;
    bit                m_active = 0;
    int                m_k = 0;
    bit                m_g = 0;
    bit                m_last = 1;
    bit                m_we = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    bit                m_done = 0;
    bit                m_started = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_active  = 0;
                m_last    = 1;
                m_rd_a    = '0;
                m_rd_b    = '0;
                m_done    = 0;
                m_started = 1;
            end else begin
                m_done = 0;
                if (m_active) begin
                    m_k++;
                    if (m_k == 4) begin
                        if (m_we) begin
                            if (m_addr < ROWS) m_mem[m_addr] = m_wdata;
                        end else if (m_g) begin
                            m_rd_b = (m_addr < ROWS) ? m_mem[m_addr] : '0;
                        end else begin
                            m_rd_a = (m_addr < ROWS) ? m_mem[m_addr] : '0;
                        end
                        m_active = 0;
                        m_done   = 1;
                    end
                end else if (bus.req_a || bus.req_b) begin
                    m_g      = (bus.req_a && bus.req_b) ? !m_last : bus.req_b;
                    m_last   = m_g;
                    m_we     = m_g ? bus.we_b    : bus.we_a;
                    m_addr   = m_g ? bus.addr_b  : bus.addr_a;
                    m_wdata  = m_g ? bus.wdata_b : bus.wdata_a;
                    m_active = 1;
                    m_k      = 0;
                end
            end
        end
    end

    logic [ROWS-1:0]   e_s;
    logic              e_on;
    logic              e_inr;
    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                e_inr = (m_addr < ROWS);
                e_on  = m_active && (m_k >= 1) && (m_k <= 3);
                e_s   = '0;
                if (m_active && m_k == 2 && e_inr) e_s[m_addr] = 1'b1;
                chk("row_S", bus.row_S, e_s);
                chk("row_op", bus.row_op, e_on ? m_we : 1'b0);
                chk("row_data_in", bus.row_data_in, (e_on && m_we) ? m_wdata : '0);
                chk("done_a", bus.done_a, m_done && !m_g);
                chk("done_b", bus.done_b, m_done && m_g);
                chk("err_a", bus.err_a, m_done && !m_g && !e_inr);
                chk("err_b", bus.err_b, m_done && m_g && !e_inr);
                chk("rdata_a", bus.rdata_a, m_rd_a);
                chk("rdata_b", bus.rdata_b, m_rd_b);
            end
        end
    end

    // Call at a falling edge; returns at the falling edge where done was seen.
    task automatic do_req(input bit side, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, output int lat, output bit err,
                          output logic [DATA_W-1:0] rd, output int s_cyc,
                          output logic [ROWS-1:0] s_val);
        bit got = 0;
        lat = 0; err = 0; rd = '0; s_cyc = 0; s_val = '0;
        if (side) begin
            bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wd; bus.req_b = 1'b1;
        end else begin
            bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wd; bus.req_a = 1'b1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.row_S != '0) begin
                s_cyc++;
                s_val = bus.row_S;
            end
            if (side ? bus.done_b : bus.done_a) begin
                got = 1;
                err = side ? bus.err_b : bus.err_a;
                rd  = side ? bus.rdata_b : bus.rdata_a;
            end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL done_timeout: side %0d got no done within 40 cycles", side);
        end
        if (side) bus.req_b = 1'b0;
        else      bus.req_a = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    int                lat;
    bit                er;
    logic [DATA_W-1:0] rd;
    int                sc;
    logic [ROWS-1:0]   sv;
    int                nd;
    int                when [3];
    logic [2:0]        order;
    bit                overlap;

    initial begin
        bus.req_a = 0; bus.we_a = 0; bus.addr_a = '0; bus.wdata_a = '0;
        bus.req_b = 0; bus.we_b = 0; bus.addr_b = '0; bus.wdata_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_row_S", bus.row_S, 0);
        chk("reset_done_a", bus.done_a, 0);
        chk("reset_rdata_a", bus.rdata_a, 0);
        rst = 1'b0;

        do_req(0, 1, 2'd1, 8'b10101010, lat, er, rd, sc, sv);
        chk("wr_a_latency", lat, 5);
        chk("wr_a_err", er, 0);
        chk("wr_a_strobe_cycles", sc, 1);
        chk("wr_a_strobe_val", sv, 3'b010);

        do_req(0, 0, 2'd1, 8'h00, lat, er, rd, sc, sv);
        chk("rd_a_row1", rd, 8'b10101010);
        chk("rd_a_err", er, 0);
        chk("rdata_b_untouched", bus.rdata_b, 0);

        do_req(1, 1, 2'd2, 8'b11001100, lat, er, rd, sc, sv);
        chk("wr_b_strobe_val", sv, 3'b100);
        do_req(1, 0, 2'd2, 8'h00, lat, er, rd, sc, sv);
        chk("rd_b_row2", rd, 8'b11001100);

        // Both requesters held high together: last grant was B, so A, B, A.
        bus.we_a = 0; bus.addr_a = 2'd1; bus.wdata_a = '0;
        bus.we_b = 1; bus.addr_b = 2'd2; bus.wdata_b = 8'b11001100;
        bus.req_a = 1; bus.req_b = 1;
        nd = 0; order = '0; overlap = 0;
        for (int c = 1; c <= 30 && nd < 3; c++) begin
            @(negedge clk);
            if (bus.done_a && bus.done_b) overlap = 1;
            if (bus.done_a) begin
                order[nd] = 1'b0; when[nd] = c; nd++;
                chk("rr_rd_a_row1", bus.rdata_a, 8'b10101010);
            end else if (bus.done_b) begin
                order[nd] = 1'b1; when[nd] = c; nd++;
            end
        end
        bus.req_a = 0; bus.req_b = 0;
        chk("rr_done_count", nd, 3);
        chk("rr_order", order, 3'b010);
        chk("rr_no_overlap", overlap, 0);
        chk("rr_first_done", when[0], 5);
        chk("rr_gap1", when[1] - when[0], 5);
        chk("rr_gap2", when[2] - when[1], 5);

        do_req(0, 1, 2'd3, 8'h55, lat, er, rd, sc, sv);
        chk("oor_wr_err", er, 1);
        chk("oor_wr_no_strobe", sc, 0);
        do_req(0, 0, 2'd3, 8'h00, lat, er, rd, sc, sv);
        chk("oor_rd_err", er, 1);
        chk("oor_rd_data", rd, 0);

        // Abort a read with reset while the row is strobed.
        bus.we_a = 0; bus.addr_a = 2'd1; bus.req_a = 1;
        nd = 0;
        for (int c = 0; c < 20 && bus.row_S == '0; c++) @(negedge clk);
        chk("abort_saw_strobe", bus.row_S, 3'b010);
        rst = 1'b1; bus.req_a = 0;
        @(negedge clk);
        chk("abort_row_S", bus.row_S, 0);
        chk("abort_done_a", bus.done_a, 0);
        chk("abort_rdata_a", bus.rdata_a, 0);
        rst = 1'b0;
        do_req(0, 0, 2'd1, 8'h00, lat, er, rd, sc, sv);
        chk("after_abort_latency", lat, 5);
        chk("after_abort_rd", rd, 8'b10101010);

        fork
            begin
                int l; bit e; logic [DATA_W-1:0] r; int s; logic [ROWS-1:0] v;
                for (int t = 0; t < 25; t++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_req(0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 3)),
                           DATA_W'($urandom_range(0, 255)), l, e, r, s, v);
                end
            end
            begin
                int l; bit e; logic [DATA_W-1:0] r; int s; logic [ROWS-1:0] v;
                for (int t = 0; t < 25; t++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_req(1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 3)),
                           DATA_W'($urandom_range(0, 255)), l, e, r, s, v);
                end
            end
        join

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
